// File: rtl/if_id_stage_reg_pkg.sv
// Shared IF/ID pipeline definitions: last-action encodings and fetch constants.
package if_id_stage_reg_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_BUBBLE = 2'd2
    } stage_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_ENC = 32'h0000_0000;
    localparam logic [31:0] PC_INCR = 32'd4;

endpackage

// File: rtl/if_id_stage_reg_if.sv
// Fetch-to-decode bundle: the fetch side drives PC/instruction/hazard controls,
// the stage register drives the ID-side outputs and debug status.
interface if_id_stage_reg_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] PCResult;
    logic [DATA_WIDTH-1:0] Instruction;
    logic                  IFIDWrite;
    logic                  Flush;
    logic [DATA_WIDTH-1:0] Instruction_ID;
    logic [DATA_WIDTH-1:0] PC_ID;
    logic [DATA_WIDTH-1:0] PCPlus4_ID;
    logic                  Valid_ID;
    logic                  AlignErr;
    logic [CNT_WIDTH-1:0]  StallCount;
    logic [CNT_WIDTH-1:0]  FlushCount;
    logic [1:0]            State;

    modport master (
        output PCResult, Instruction, IFIDWrite, Flush,
        input  Instruction_ID, PC_ID, PCPlus4_ID, Valid_ID,
        input  AlignErr, StallCount, FlushCount, State
    );

    modport slave (
        input  PCResult, Instruction, IFIDWrite, Flush,
        output Instruction_ID, PC_ID, PCPlus4_ID, Valid_ID,
        output AlignErr, StallCount, FlushCount, State
    );
endinterface

// File: rtl/if_id_stage_reg_sat_counter.sv
// Enabled up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with stall hold, flush/misalignment bubbles,
// sticky alignment error and saturating stall/flush debug counters.
//
//   state  | meaning
//   RUN    | last edge captured a fetch (or a misaligned-PC bubble)
//   STALL  | last edge held contents because IFIDWrite was low
//   BUBBLE | last edge squashed the fetch because of Flush
module if_id_stage_reg
    import if_id_stage_reg_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_ENC),
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    if_id_stage_reg_if.slave   bus
);

    logic [DATA_WIDTH-1:0] instr_q;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_plus4_q;
    logic                  valid_q;
    logic                  align_err_q;
    stage_state_t          state_q;
    logic                  stall_en;
    logic                  flush_en;

    // State is informational only; the next edge depends solely on inputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            pc_plus4_q  <= '0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b0;
            state_q     <= ST_RUN;
        end else if (bus.Flush) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
            state_q    <= ST_BUBBLE;
        end else if (!bus.IFIDWrite) begin
            state_q <= ST_STALL;
        end else if (bus.PCResult[1:0] == 2'b00) begin
            instr_q    <= bus.Instruction;
            pc_q       <= bus.PCResult;
            pc_plus4_q <= bus.PCResult + DATA_WIDTH'(PC_INCR);
            valid_q    <= 1'b1;
            state_q    <= ST_RUN;
        end else begin
            // Misaligned fetch: bubble like a flush, but not counted as one.
            instr_q     <= NOP_INSTR;
            pc_q        <= '0;
            pc_plus4_q  <= '0;
            valid_q     <= 1'b0;
            align_err_q <= 1'b1;
            state_q     <= ST_RUN;
        end
    end

    always_comb begin
        flush_en = bus.Flush;
        stall_en = !bus.Flush && !bus.IFIDWrite;
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .en    (stall_en),
        .count (bus.StallCount)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .en    (flush_en),
        .count (bus.FlushCount)
    );

    assign bus.Instruction_ID = instr_q;
    assign bus.PC_ID          = pc_q;
    assign bus.PCPlus4_ID     = pc_plus4_q;
    assign bus.Valid_ID       = valid_q;
    assign bus.AlignErr       = align_err_q;
    assign bus.State          = state_q;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: directed steps plus random traffic against a
// rule-level model, run on a default instance and a 4-bit-counter instance.
module tb_if_id_stage_reg;

    logic clk;
    logic reset;

    if_id_stage_reg_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
    if_id_stage_reg_if #(.DATA_WIDTH(32), .CNT_WIDTH(4))  bus_b ();

    if_id_stage_reg #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus_a)
    );

    if_id_stage_reg #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut_sat (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [31:0] m_instr, m_pc, m_p4;
    logic        m_valid, m_aerr;
    int          m_state;
    longint      m_sc, m_fc;

    function automatic longint sat(longint c, int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("instr_id",   bus_a.Instruction_ID, m_instr);
        check("pc_id",      bus_a.PC_ID,          m_pc);
        check("pcplus4_id", bus_a.PCPlus4_ID,     m_p4);
        check("valid_id",   32'(bus_a.Valid_ID),  32'(m_valid));
        check("align_err",  32'(bus_a.AlignErr),  32'(m_aerr));
        check("state",      32'(bus_a.State),     32'(m_state));
        check("stall_cnt",  32'(bus_a.StallCount), 32'(sat(m_sc, 16)));
        check("flush_cnt",  32'(bus_a.FlushCount), 32'(sat(m_fc, 16)));
        check("sat_pc_id",  bus_b.PC_ID,          m_pc);
        check("sat_stall_cnt", 32'(bus_b.StallCount), 32'(sat(m_sc, 4)));
        check("sat_flush_cnt", 32'(bus_b.FlushCount), 32'(sat(m_fc, 4)));
    endtask

    task automatic model_reset();
        m_instr = 32'h0; m_pc = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
        m_aerr = 1'b0; m_state = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0; m_pc = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
    endtask

    task automatic model_edge(logic fl, logic wr, logic [31:0] pc, logic [31:0] ins);
        if (fl) begin
            model_bubble();
            m_fc++;
            m_state = 2;
        end else if (!wr) begin
            m_sc++;
            m_state = 1;
        end else if (pc % 4 == 0) begin
            m_instr = ins; m_pc = pc; m_p4 = 32'((64'(pc) + 4) % 64'h1_0000_0000);
            m_valid = 1'b1;
            m_state = 0;
        end else begin
            model_bubble();
            m_aerr = 1'b1;
            m_state = 0;
        end
    endtask

    task automatic step(logic fl, logic wr, logic [31:0] pc, logic [31:0] ins);
        @(negedge clk);
        reset = 1'b1;
        bus_a.Flush = fl; bus_a.IFIDWrite = wr; bus_a.PCResult = pc; bus_a.Instruction = ins;
        bus_b.Flush = fl; bus_b.IFIDWrite = wr; bus_b.PCResult = pc; bus_b.Instruction = ins;
        @(posedge clk);
        model_edge(fl, wr, pc, ins);
        #1;
        check_all();
    endtask

    // Reset lands between edges; outputs must change before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        #1;
        check_all();
    endtask

    logic        r_fl, r_wr;
    logic [31:0] r_pc, r_ins;
    int          sel;

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        bus_a.Flush = 1'b0; bus_a.IFIDWrite = 1'b0; bus_a.PCResult = '0; bus_a.Instruction = '0;
        bus_b.Flush = 1'b0; bus_b.IFIDWrite = 1'b0; bus_b.PCResult = '0; bus_b.Instruction = '0;
        model_reset();

        async_reset();
        step(1'b0, 1'b1, 32'h0000_0000, 32'h2008_0005);

        step(1'b0, 1'b1, 32'h0000_0010, 32'h8C09_0004);
        repeat (3) step(1'b0, 1'b0, 32'h0000_0014, 32'h0129_5020);

        step(1'b1, 1'b0, 32'h0000_0014, 32'h0129_5020);
        step(1'b0, 1'b1, 32'h0000_0018, 32'h1000_FFFF);

        step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0800_0000);
        step(1'b0, 1'b1, 32'h0000_0006, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'h0000_0020, 32'h2129_0001);
        step(1'b0, 1'b1, 32'h0000_0024, 32'h2129_0002);

        repeat (2) step(1'b0, 1'b0, 32'h0000_0028, 32'h0);
        check("stall_cnt_before_reset", 32'(bus_a.StallCount), 32'd5);
        async_reset();

        step(1'b0, 1'b1, 32'h0000_0100, 32'h3C01_1234);
        repeat (20) step(1'b0, 1'b0, 32'h0000_0104, 32'h0);
        check("sat_stall_stops_at_15", 32'(bus_b.StallCount), 32'd15);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) async_reset();
            r_fl  = ($urandom_range(0, 5) == 0);
            r_wr  = ($urandom_range(0, 3) != 0);
            sel   = $urandom_range(0, 9);
            r_ins = $urandom;
            if (sel == 0)      r_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else if (sel == 1) r_pc = $urandom;
            else               r_pc = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            step(r_fl, r_wr, r_pc, r_ins);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- IF/ID pipeline register directly downstream of the program counter.
- Captures each fetched instruction and its PC every cycle, and computes PC+4 for the ID stage.
- Supports load-use stalls through IFIDWrite, which the hazard unit drives in lockstep with PCWrite.
- Inserts a bubble on a taken branch or jump (Flush), flags misaligned fetch PCs, and keeps saturating stall and flush counters for debug.

Parameters:
- DATA_WIDTH, 32, width of PC and instruction words.
- NOP_INSTR, 32'h00000000, encoding injected on bubble or reset (sll $0,$0,0).
- CNT_WIDTH, 16, width of the StallCount and FlushCount performance counters.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- PCResult  in  DATA_WIDTH  current PC from the program counter register.
- Instruction  in  DATA_WIDTH  instruction memory read data for PCResult (combinational, same cycle).
- IFIDWrite  in  1  1 = capture new fetch; 0 = hold (stall).
- Flush  in  1  1 = squash the current fetch and load a bubble.
- Instruction_ID  out  DATA_WIDTH  registered instruction to decode.
- PC_ID  out  DATA_WIDTH  registered PC of Instruction_ID.
- PCPlus4_ID  out  DATA_WIDTH  registered PC_ID+4.
- Valid_ID  out  1  1 = Instruction_ID is a real fetched instruction.
- AlignErr  out  1  sticky flag: a misaligned PC was presented for capture.
- StallCount  out  CNT_WIDTH  cycles spent stalled.
- FlushCount  out  CNT_WIDTH  bubbles inserted.
- State  out  2  last action: 0 RUN, 1 STALL, 2 BUBBLE.

Behaviour:
- Reset low, asynchronous, at any time including mid-stall:
  - Instruction_ID=NOP_INSTR, PC_ID=0, PCPlus4_ID=0, Valid_ID=0.
  - AlignErr=0, StallCount=0, FlushCount=0, State=RUN.
- Reset release: the first rising edge with Reset high evaluates the inputs normally; no extra dead cycle.
- Every rising edge evaluates in priority order:
  1. Flush=1 (regardless of IFIDWrite):
     - Instruction_ID=NOP_INSTR, PC_ID=0, PCPlus4_ID=0, Valid_ID=0.
     - FlushCount+1, State=BUBBLE.
  2. Flush=0 and IFIDWrite=0:
     - All data outputs and Valid_ID hold.
     - StallCount+1, State=STALL.
  3. Flush=0 and IFIDWrite=1 and PCResult[1:0]==0:
     - Instruction_ID=Instruction, PC_ID=PCResult, PCPlus4_ID=PCResult+4, Valid_ID=1.
     - State=RUN.
  4. Flush=0 and IFIDWrite=1 and PCResult[1:0]!=0:
     - Load a bubble exactly as in case 1, but FlushCount is not incremented.
     - AlignErr=1 (sticky until reset), State=RUN.
- Latency: one cycle from PCResult/Instruction to the ID outputs.
- PCPlus4_ID arithmetic is modulo 2^DATA_WIDTH: 32'hFFFFFFFC gives 0; no carry-out.
- Counters saturate at all-ones and never wrap.
- Stall duration is unbounded; a hold keeps the same contents for any number of cycles.
- Flush while stalled: the bubble still replaces the held instruction.
- State is a registered indicator only. It does not gate any behaviour; the next-edge result depends solely on the current inputs.
- No combinational path from inputs to outputs.

Decomposition:
- Shared pipeline package holds:
  - the State encodings RUN=2'd0, STALL=2'd1, BUBBLE=2'd2;
  - the NOP_INSTR constant;
  - the PC increment constant 4.
- Natural sub-module: sat_counter (CNT_WIDTH, enable, async active-low reset, saturate at max), instantiated twice for StallCount and FlushCount.

Test Plan:
- Reset then fetch: Reset=0 for 2 cycles, then Reset=1 with PCResult=0x00000000, Instruction=0x20080005, IFIDWrite=1 → next edge gives Instruction_ID=0x20080005, PC_ID=0, PCPlus4_ID=4, Valid_ID=1, State=0.
- Stall: capture PC=0x10, then IFIDWrite=0 for 3 cycles while PCResult=0x14 → outputs keep PC_ID=0x10 for all 3 cycles; StallCount=3, State=1.
- Flush priority: Flush=1 and IFIDWrite=0 on the same edge → Instruction_ID=0, Valid_ID=0, PC_ID=0, FlushCount=1, StallCount unchanged, State=2; the next normal edge captures again.
- Wrap and misalignment:
  - PCResult=0xFFFFFFFC → PCPlus4_ID=0x00000000.
  - Then PCResult=0x00000006 → bubble loaded, AlignErr=1, FlushCount unchanged.
  - AlignErr stays 1 through later aligned fetches until reset.
- Async reset mid-stall: assert Reset=0 between clock edges while stalled with StallCount=5 → all outputs reach reset values immediately, without waiting for a clock edge.
- Saturation: with CNT_WIDTH=4, hold IFIDWrite=0 for 20 cycles → StallCount stops at 15.
